ibus_fetch_ctrl: RTL and testbench
==================================

// Module: ibus_fetch_ctrl
// PURPOSE
//  Instruction-bus transaction controller between the fetch PC-select logic and instruction memory.
//  Takes one fetch address per handshake and issues it on ibus_req_t.
//  Tracks addr_ok/data_ok, buffers the returned word for decode and back-pressures the PC register.
//  Discards in-flight fetches on a branch/jump redirect (flush), so decode never sees a wrong-path word.
// PARAMETERS
//  ALIGN_CHECK  1  1: pc[1:0]!=0 raises adel_o with no bus request; 0: low bits ignored (forced to 0 on bus)
// PORTS
//  clk            in   1   clock, all state on posedge
//  reset          in   1   asynchronous, active-high reset
//  pc_i           in   32  next fetch address from PC-select
//  pc_valid_i     in   1   pc_i is presented
//  pc_ready_o     out  1   pc_i accepted this cycle when pc_valid_i & pc_ready_o
//  flush_i        in   1   redirect: kill held and in-flight fetch
//  dstall_i       in   1   decode cannot take the held word this cycle
//  ireq           out  ibus_req_t   {valid, addr[31:0]} to instruction bus
//  iresp          in   ibus_resp_t  {addr_ok, data_ok, data[31:0]} from instruction bus
//  instr_o        out  32  fetched instruction (valid with instr_valid_o)
//  pc_o           out  32  address of instr_o
//  instr_valid_o  out  1   instr_o/pc_o/adel_o meaningful
//  adel_o         out  1   fetch-address misaligned (ALIGN_CHECK=1); instr_o=0
// BEHAVIOUR
//  Interface: one clock clk; reset is asynchronous and active-high.
//  Reset: state=IDLE, drop=0, ireq.valid=0, ireq.addr=0, instr_o=0, pc_o=0, instr_valid_o=0, adel_o=0.
//  States: IDLE, REQ (ireq.valid=1, wait addr_ok), WAIT (wait data_ok), HOLD (word held for decode).
//  pc_ready_o = ~reset & (IDLE | (HOLD & (~dstall_i | flush_i))), combinational.
//  Accept: pc latched into addr_q; if misaligned & ALIGN_CHECK -> HOLD with adel_o=1, instr_o=0.
//   Otherwise -> REQ.
//  REQ: ireq.valid=1, ireq.addr=addr_q stable until addr_ok sampled high. No withdrawal, even on flush.
//   addr_ok & ~data_ok -> WAIT.
//   addr_ok & data_ok same cycle -> completes as data_ok below.
//  WAIT/REQ on data_ok: drop=0 -> capture data, pc_o=addr_q, go HOLD.
//   drop=1 -> discard, clear drop, go IDLE.
//  HOLD: instr_valid_o=1. Leaves on ~dstall_i, or on flush_i regardless of dstall_i.
//   New pc accepted same cycle -> REQ/HOLD; else -> IDLE, instr_valid_o=0.
//  Latency (zero-wait bus, addr_ok&data_ok in first REQ cycle): accept in N, ireq.valid in N+1,
//   instr_valid_o in N+2.
//  Throughput: one fetch per 2 cycles minimum; no outstanding-request pipelining (one in flight max).
//  flush_i in IDLE: no effect; pc_i accepted normally.
//  flush_i in HOLD: held word dropped (instr_valid_o low next cycle unless refilled).
//   pc_i in that cycle is accepted (redirect target).
//  flush_i in REQ/WAIT: set drop; pc_ready_o=0. Returning data is discarded; upstream re-presents target.
//   flush_i coincident with data_ok: word discarded (treated as drop=1).
//  data_ok in IDLE/HOLD is a bus protocol violation: ignored, no state change.
//  Reset asserted mid-transaction: immediate return to reset values.
//   Bus responses after reset release are ignored in IDLE.
// TESTING
//  1 zero-wait: pc_i=0xbfc00000 accepted, addr_ok&data_ok=1 data=0x24080001 next cycle
//    -> instr_valid_o=1, instr_o=0x24080001, pc_o=0xbfc00000 two cycles after accept.
//  2 wait states: addr_ok after 3 cycles, data_ok 2 later
//    -> ireq.addr stable throughout REQ, pc_ready_o=0 until HOLD, one valid word delivered.
//  3 flush in WAIT: pc 0xbfc00010 in flight, flush_i=1, data_ok with 0xdeadbeef
//    -> instr_valid_o stays 0, next pc (0xbfc00100) fetched and delivered.
//  4 decode stall: HOLD with dstall_i=1 for 4 cycles
//    -> instr_o/pc_o constant, pc_ready_o=0; dstall_i=0 with pc_valid_i -> next fetch issues next cycle.
//  5 misaligned: pc_i=0xbfc00002, ALIGN_CHECK=1
//    -> ireq.valid never 1, instr_valid_o=1 & adel_o=1 & pc_o=0xbfc00002 next cycle.
//  6 reset in REQ: assert reset async mid-cycle -> ireq.valid=0 immediately, state IDLE, outputs 0.

Source files
------------

// File: rtl/ibus_fetch_ctrl.sv
// Instruction-bus fetch controller: issues one fetch at a time, buffers the returned
// word for decode, and discards wrong-path data after a flush.
module ibus_fetch_ctrl #(
  parameter bit ALIGN_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_i,
  input  logic        pc_valid_i,
  output logic        pc_ready_o,
  input  logic        flush_i,
  input  logic        dstall_i,
  output logic [32:0] ireq,           // {valid, addr[31:0]}
  input  logic [33:0] iresp,          // {addr_ok, data_ok, data[31:0]}
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic        instr_valid_o,
  output logic        adel_o
);

  localparam int unsigned REQ_VALID_BIT = 32;
  localparam int unsigned RSP_AOK_BIT   = 33;
  localparam int unsigned RSP_DOK_BIT   = 32;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_e;

  state_e      state_q, state_d;
  logic        drop_q, drop_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic        adel_q, adel_d;

  logic        addr_ok, data_ok;
  logic [31:0] rdata;
  logic        accept, misaligned, complete, hold_leave;

  assign addr_ok = iresp[RSP_AOK_BIT];
  assign data_ok = iresp[RSP_DOK_BIT];
  assign rdata   = iresp[31:0];

  assign hold_leave = (state_q == HOLD) && (!dstall_i || flush_i);
  assign pc_ready_o = !reset && ((state_q == IDLE) || hold_leave);
  assign accept     = pc_valid_i && pc_ready_o;
  assign misaligned = ALIGN_CHECK && (pc_i[1:0] != 2'b00);
  assign complete   = ((state_q == REQ) && addr_ok && data_ok) ||
                      ((state_q == WAIT) && data_ok);

  always_comb begin
    // NOTE: every _d gets its hold value first so no path through this block infers a latch.
    state_d = state_q;
    drop_d  = drop_q;
    addr_d  = addr_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    adel_d  = adel_q;

    unique case (state_q)
      IDLE: ;
      HOLD: if (hold_leave) state_d = IDLE;
      REQ, WAIT: begin
        if (flush_i) drop_d = 1'b1;
        if ((state_q == REQ) && addr_ok && !data_ok) state_d = WAIT;
        if (complete) begin
          drop_d = 1'b0;
          // A flush in the completing cycle kills the word just like an earlier one.
          if (drop_q || flush_i) begin
            state_d = IDLE;
          end else begin
            state_d = HOLD;
            instr_d = rdata;
            pc_d    = addr_q;
            adel_d  = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Only possible in IDLE or a departing HOLD, so it never fights the case above.
    if (accept) begin
      addr_d = pc_i;
      if (misaligned) begin
        state_d = HOLD;
        adel_d  = 1'b1;
        instr_d = '0;
        pc_d    = pc_i;
      end else begin
        state_d = REQ;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      drop_q  <= 1'b0;
      addr_q  <= '0;
      instr_q <= '0;
      pc_q    <= '0;
      adel_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      adel_q  <= adel_d;
    end
  end

  always_comb begin
    ireq                = '0;
    ireq[REQ_VALID_BIT] = (state_q == REQ);
    ireq[31:0]          = {addr_q[31:2], 2'b00};
  end

  assign instr_o       = instr_q;
  assign pc_o          = pc_q;
  assign instr_valid_o = (state_q == HOLD);
  assign adel_o        = adel_q;

endmodule

// File: tb/tb_ibus_fetch_ctrl.sv
// Randomized bench for ibus_fetch_ctrl against a transaction-level fetch model,
// plus directed zero-wait, flush, misaligned and mid-transaction reset scenarios.
module tb_ibus_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_i;
  logic        pc_valid_i;
  logic        pc_ready_o;
  logic        flush_i;
  logic        dstall_i;
  logic [32:0] ireq;
  logic [33:0] iresp;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        instr_valid_o;
  logic        adel_o;

  ibus_fetch_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .pc_i         (pc_i),
    .pc_valid_i   (pc_valid_i),
    .pc_ready_o   (pc_ready_o),
    .flush_i      (flush_i),
    .dstall_i     (dstall_i),
    .ireq         (ireq),
    .iresp        (iresp),
    .instr_o      (instr_o),
    .pc_o         (pc_o),
    .instr_valid_o(instr_valid_o),
    .adel_o       (adel_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: one outstanding fetch and one held word.
  bit          m_busy, m_addr_done, m_doomed;
  bit          m_hold, m_adel;
  logic [31:0] m_pc, m_hold_pc, m_hold_instr;
  int          a_wait, d_wait;
  int          lat_a, lat_d;

  task automatic model_reset();
    m_busy = 0; m_addr_done = 0; m_doomed = 0;
    m_hold = 0; m_adel = 0;
    m_pc = '0; m_hold_pc = '0; m_hold_instr = '0;
  endtask

  task automatic cycle(input bit pv, input logic [31:0] pc, input bit fl, input bit ds,
                       input bit stray, input logic [31:0] rdata);
    bit aok, dok, ready, accept, done;
    @(negedge clk);
    aok = 0;
    dok = 0;
    if (m_busy && !m_addr_done) begin
      if (a_wait == 0) begin
        aok = 1;
        dok = (d_wait == 0);
      end else a_wait--;
    end else if (m_busy) begin
      if (d_wait == 0) dok = 1;
      else d_wait--;
    end else dok = stray;
    pc_valid_i = pv;
    pc_i       = pc;
    flush_i    = fl;
    dstall_i   = ds;
    iresp      = {aok, dok, rdata};
    #1;
    ready = !m_busy && (!m_hold || !ds || fl);
    check("pc_ready", 32'(pc_ready_o), 32'(ready));
    check("ireq_valid", 32'(ireq[32]), 32'(m_busy && !m_addr_done));
    if (m_busy && !m_addr_done) check("ireq_addr", ireq[31:0], {m_pc[31:2], 2'b00});
    check("instr_valid", 32'(instr_valid_o), 32'(m_hold));
    if (m_hold) begin
      check("instr", instr_o, m_hold_instr);
      check("pc_o", pc_o, m_hold_pc);
      check("adel", 32'(adel_o), 32'(m_adel));
    end
    // Advance the model through the coming clock edge.
    accept = pv && ready;
    if (m_busy) begin
      done = 0;
      if (fl) m_doomed = 1;
      if (!m_addr_done) begin
        if (aok) begin
          m_addr_done = 1;
          done = dok;
        end
      end else done = dok;
      if (done) begin
        m_busy = 0;
        if (!m_doomed) begin
          m_hold = 1; m_adel = 0; m_hold_instr = rdata; m_hold_pc = m_pc;
        end
        m_doomed = 0;
      end
    end else begin
      if (m_hold && (!ds || fl)) m_hold = 0;
      if (accept) begin
        if (pc[1:0] != 2'b00) begin
          m_hold = 1; m_adel = 1; m_hold_instr = '0; m_hold_pc = pc;
        end else begin
          m_busy = 1; m_addr_done = 0; m_doomed = 0; m_pc = pc;
          a_wait = lat_a; d_wait = lat_d;
        end
      end
    end
  endtask

  task automatic reset_in_req();
    @(negedge clk);
    pc_valid_i = 0; flush_i = 0; dstall_i = 0; iresp = '0;
    #1 check("rst_pre_ireq_valid", 32'(ireq[32]), 32'd1);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("rst_ireq_valid", 32'(ireq[32]), 32'd0);
    check("rst_ireq_addr", ireq[31:0], 32'd0);
    check("rst_instr_valid", 32'(instr_valid_o), 32'd0);
    check("rst_pc_ready", 32'(pc_ready_o), 32'd0);
    check("rst_instr", instr_o, 32'd0);
    check("rst_pc_o", pc_o, 32'd0);
    check("rst_adel", 32'(adel_o), 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] p;
    reset = 1'b0; pc_i = '0; pc_valid_i = 0; flush_i = 0; dstall_i = 0; iresp = '0;
    lat_a = 0; lat_d = 0; a_wait = 0; d_wait = 0;
    model_reset();
    #1 reset = 1'b1;
    #2;
    check("init_ireq", {31'd0, ireq[32]}, 32'd0);
    check("init_instr_valid", 32'(instr_valid_o), 32'd0);
    check("init_pc_ready", 32'(pc_ready_o), 32'd0);
    check("init_instr", instr_o, 32'd0);
    check("init_pc_o", pc_o, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Zero-wait fetch: word visible two edges after acceptance.
    lat_a = 0; lat_d = 0;
    cycle(1, 32'hbfc00000, 0, 0, 0, 32'h0);
    cycle(0, 32'h0, 0, 0, 0, 32'h24080001);
    @(posedge clk); #1;
    check("t1_instr_valid", 32'(instr_valid_o), 32'd1);
    check("t1_instr", instr_o, 32'h24080001);
    check("t1_pc_o", pc_o, 32'hbfc00000);
    cycle(0, 32'h0, 0, 0, 0, 32'h0);

    // Flush while waiting for data: returning word is discarded.
    lat_a = 0; lat_d = 2;
    cycle(1, 32'hbfc00010, 0, 0, 0, 32'h0);
    cycle(0, 32'h0, 0, 0, 0, 32'h0);
    cycle(0, 32'h0, 1, 0, 0, 32'h0);
    cycle(0, 32'h0, 0, 0, 0, 32'h0);
    cycle(0, 32'h0, 0, 0, 0, 32'hdeadbeef);
    @(posedge clk); #1;
    check("t3_dropped", 32'(instr_valid_o), 32'd0);
    lat_a = 0; lat_d = 0;
    cycle(1, 32'hbfc00100, 0, 0, 0, 32'h0);
    cycle(0, 32'h0, 0, 0, 0, 32'h11111111);
    @(posedge clk); #1;
    check("t3_refetch_pc", pc_o, 32'hbfc00100);
    check("t3_refetch_instr", instr_o, 32'h11111111);
    cycle(0, 32'h0, 0, 0, 0, 32'h0);

    // Misaligned address: error word without a bus request.
    cycle(1, 32'hbfc00002, 0, 0, 1, 32'h0);
    @(posedge clk); #1;
    check("t5_ireq_valid", 32'(ireq[32]), 32'd0);
    check("t5_instr_valid", 32'(instr_valid_o), 32'd1);
    check("t5_adel", 32'(adel_o), 32'd1);
    check("t5_pc_o", pc_o, 32'hbfc00002);
    check("t5_instr", instr_o, 32'd0);
    cycle(0, 32'h0, 0, 0, 0, 32'h0);

    for (int i = 0; i < 4000; i++) begin
      if (m_busy && !m_addr_done && ($urandom_range(0, 39) == 0)) begin
        reset_in_req();
      end else begin
        p = 32'hbfc00000 + ($urandom_range(0, 255) << 2);
        if ($urandom_range(0, 7) == 0) p[1:0] = 2'($urandom_range(1, 3));
        lat_a = $urandom_range(0, 3);
        lat_d = $urandom_range(0, 3);
        cycle($urandom_range(0, 9) < 7, p, $urandom_range(0, 9) == 0,
              $urandom_range(0, 9) < 4, $urandom_range(0, 9) == 0, $urandom);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
